// File: rtl/regfile_pkg.sv
// Shared definitions for the multi-port register file: clear-FSM state
// encodings and the depth helper used to size the storage array.
package regfile_pkg;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_CLEAR = 1'b1;

  function automatic int rf_depth(input int addr_w);
    return 1 << addr_w;
  endfunction

endpackage

// File: rtl/regfile_clear_fsm.sv
// Sequential clear engine: sweeps every entry to zero after reset or on
// request, exposing one write strobe/address and a registered busy flag.
module regfile_clear_fsm
  import regfile_pkg::*;
#(
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear_req,
  output logic              busy,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(rf_depth(ADDR_W) - 1);

  logic [0:0]        state;
  logic [ADDR_W-1:0] cnt;

  // Reset always restarts the sweep from entry 0, even mid-sweep.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_CLEAR;
      cnt   <= '0;
      busy  <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (clear_req) begin
            state <= ST_CLEAR;
            cnt   <= '0;
            busy  <= 1'b1;
          end
        end
        default: begin
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end
      endcase
    end
  end

  // No entry is touched while reset is held.
  assign clr_we   = (state == ST_CLEAR) && !reset;
  assign clr_addr = cnt;

endmodule

// File: rtl/register_file_mp.sv
// Parametrised multi-port register file for the decode stage: N combinational
// read ports, up to two write ports, hardwired zero entry, optional bypass.
module register_file_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 1,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_WR-1:0]        we,
  input  logic [NUM_WR*ADDR_W-1:0] wa,
  input  logic [NUM_WR*DATA_W-1:0] wd,
  input  logic [NUM_RD*ADDR_W-1:0] ra,
  output logic [NUM_RD*DATA_W-1:0] rd,
  input  logic                     clear_req,
  output logic                     busy
);

  localparam int DEPTH = rf_depth(ADDR_W);

  logic [DATA_W-1:0] mem [DEPTH];
  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;
  logic              wr_ok;
  logic [NUM_WR-1:0] wr_en;

  regfile_clear_fsm #(
    .ADDR_W(ADDR_W)
  ) u_clear (
    .clk      (clk),
    .reset    (reset),
    .clear_req(clear_req),
    .busy     (busy),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );

  // User writes are dropped (not queued) during a sweep or while in reset.
  assign wr_ok = !busy && !reset;

  always_comb begin
    wr_en = '0;
    for (int i = 0; i < NUM_WR; i++) begin
      wr_en[i] = wr_ok && we[i] &&
                 !((ZERO_REG != 0) && (wa[i*ADDR_W +: ADDR_W] == '0));
    end
  end

  // Later loop iterations override earlier ones: the higher-index port wins.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[clr_addr] <= '0;
    end else begin
      for (int i = 0; i < NUM_WR; i++) begin
        if (wr_en[i]) begin
          mem[wa[i*ADDR_W +: ADDR_W]] <= wd[i*DATA_W +: DATA_W];
        end
      end
    end
  end

  for (genvar r = 0; r < NUM_RD; r++) begin : g_rd
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] v;

    assign a = ra[r*ADDR_W +: ADDR_W];

    always_comb begin
      v = mem[a];
      if (BYPASS != 0) begin
        for (int w = 0; w < NUM_WR; w++) begin
          if (wr_en[w] && (wa[w*ADDR_W +: ADDR_W] == a)) begin
            v = wd[w*DATA_W +: DATA_W];
          end
        end
      end
      if (busy || ((ZERO_REG != 0) && (a == '0))) begin
        v = '0;
      end
    end

    assign rd[r*DATA_W +: DATA_W] = v;
  end

endmodule

// File: tb/tb_register_file_mp.sv
// Directed scoreboard bench: instance A is 2R/2W with bypass and zero entry,
// instance B is 1R/1W without bypass and with a writable entry 0.
module tb_register_file_mp;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [1:0]  we_a;
  logic [9:0]  wa_a;
  logic [63:0] wd_a;
  logic [9:0]  ra_a;
  logic [63:0] rd_a;
  logic        clear_req_a;
  logic        busy_a;

  logic        we_b;
  logic [4:0]  wa_b;
  logic [31:0] wd_b;
  logic [4:0]  ra_b;
  logic [31:0] rd_b;
  logic        clear_req_b;
  logic        busy_b;

  register_file_mp #(
    .DATA_W(32), .ADDR_W(5), .NUM_RD(2), .NUM_WR(2), .ZERO_REG(1), .BYPASS(1)
  ) dut_a (
    .clk(clk), .reset(reset), .we(we_a), .wa(wa_a), .wd(wd_a),
    .ra(ra_a), .rd(rd_a), .clear_req(clear_req_a), .busy(busy_a)
  );

  register_file_mp #(
    .DATA_W(32), .ADDR_W(5), .NUM_RD(1), .NUM_WR(1), .ZERO_REG(0), .BYPASS(0)
  ) dut_b (
    .clk(clk), .reset(reset), .we(we_b), .wa(wa_b), .wd(wd_b),
    .ra(ra_b), .rd(rd_b), .clear_req(clear_req_b), .busy(busy_b)
  );

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic push(input string tag, input logic [31:0] e);
    exp_t x;
    x.tag = tag;
    x.exp = e;
    sb.push_back(x);
  endtask

  task automatic pop_check(input logic [31:0] obs);
    exp_t x;
    n_cmp++;
    if (sb.size() == 0) begin
      n_bad++;
      $error("FAIL sb_empty observed=%h required=<none>", obs);
      return;
    end
    x = sb.pop_front();
    assert (obs === x.exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h required=%h", x.tag, obs, x.exp);
    end
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;

    reset = 1'b1;
    we_a = '0; wa_a = '0; wd_a = '0; ra_a = '0; clear_req_a = 1'b0;
    we_b = '0; wa_b = '0; wd_b = '0; ra_b = '0; clear_req_b = 1'b0;

    // Reset state
    @(negedge clk); @(negedge clk); settle();
    push("reset_busy_a", 32'd1);   pop_check({31'd0, busy_a});
    push("reset_busy_b", 32'd1);   pop_check({31'd0, busy_b});
    push("reset_rd_a0", 32'd0);    pop_check(rd_a[31:0]);

    @(negedge clk);
    reset = 1'b0;
    settle();
    n = 0;
    for (int k = 0; k < 200; k++) begin
      if (!busy_a) break;
      n++;
      @(negedge clk); settle();
    end
    push("init_busy_cycles", 32'd32); pop_check(n);
    push("init_busy_b", 32'd0);       pop_check({31'd0, busy_b});

    for (int i = 0; i < 32; i++) begin
      ra_a = {5'(31 - i), 5'(i)};
      ra_b = 5'(i);
      settle();
      push($sformatf("init_zero_a0_r%0d", i), 32'd0); pop_check(rd_a[31:0]);
      push($sformatf("init_zero_a1_r%0d", 31 - i), 32'd0); pop_check(rd_a[63:32]);
      push($sformatf("init_zero_b_r%0d", i), 32'd0); pop_check(rd_b);
    end

    // Same-address dual write: port 1 wins (bypass and stored)
    @(negedge clk);
    we_a = 2'b11; wa_a = {5'd5, 5'd5}; wd_a = {32'h22222222, 32'h11111111};
    ra_a = {5'd5, 5'd5};
    settle();
    push("prio_bypass", 32'h22222222); pop_check(rd_a[31:0]);
    @(negedge clk);
    we_a = 2'b00; settle();
    push("prio_stored", 32'h22222222); pop_check(rd_a[31:0]);

    // Port 1 alone to a distinct address
    we_a = 2'b10; wa_a = {5'd9, 5'd0}; wd_a = {32'h12345678, 32'h0};
    @(negedge clk);
    we_a = 2'b00; ra_a = {5'd5, 5'd9}; settle();
    push("port1_write", 32'h12345678); pop_check(rd_a[31:0]);
    push("port1_keep5", 32'h22222222); pop_check(rd_a[63:32]);

    // Bypass on A, no bypass on B
    we_a = 2'b01; wa_a = {5'd0, 5'd7}; wd_a = {32'h0, 32'hDEADBEEF};
    ra_a = {5'd7, 5'd7};
    we_b = 1'b1; wa_b = 5'd7; wd_b = 32'hDEADBEEF; ra_b = 5'd7;
    settle();
    push("bypass_a0", 32'hDEADBEEF);   pop_check(rd_a[31:0]);
    push("bypass_a1", 32'hDEADBEEF);   pop_check(rd_a[63:32]);
    push("nobypass_b_old", 32'd0);     pop_check(rd_b);
    @(negedge clk);
    we_a = 2'b00; we_b = 1'b0; settle();
    push("nobypass_b_new", 32'hDEADBEEF); pop_check(rd_b);
    push("bypass_a_stored", 32'hDEADBEEF); pop_check(rd_a[31:0]);

    // Entry 0: hardwired on A, ordinary on B
    we_a = 2'b01; wa_a = {5'd0, 5'd0}; wd_a = {32'h0, 32'hFFFFFFFF}; ra_a = {5'd0, 5'd0};
    we_b = 1'b1; wa_b = 5'd0; wd_b = 32'hFFFFFFFF; ra_b = 5'd0;
    settle();
    push("zero_bypass_a", 32'd0); pop_check(rd_a[31:0]);
    push("zero_b_old", 32'd0);    pop_check(rd_b);
    @(negedge clk);
    we_a = 2'b00; we_b = 1'b0; settle();
    push("zero_stored_a", 32'd0);        pop_check(rd_a[31:0]);
    push("zero_b_new", 32'hFFFFFFFF);    pop_check(rd_b);

    // Clear request with r3 loaded and a write to r4 during the sweep
    we_a = 2'b01; wa_a = {5'd0, 5'd3}; wd_a = {32'h0, 32'hA5A5A5A5};
    @(negedge clk);
    we_a = 2'b00; ra_a = {5'd0, 5'd3}; settle();
    push("r3_loaded", 32'hA5A5A5A5); pop_check(rd_a[31:0]);
    clear_req_a = 1'b1;
    @(negedge clk);
    clear_req_a = 1'b0;
    we_a = 2'b01; wa_a = {5'd0, 5'd4}; wd_a = {32'h0, 32'h44444444};
    ra_a = {5'd3, 5'd4};
    settle();
    n = 0;
    for (int k = 0; k < 200; k++) begin
      if (!busy_a) break;
      n++;
      push($sformatf("busy_rd0_c%0d", k), 32'd0); pop_check(rd_a[31:0]);
      push($sformatf("busy_rd1_c%0d", k), 32'd0); pop_check(rd_a[63:32]);
      @(negedge clk);
      if (k == 3) we_a = 2'b00;
      settle();
    end
    we_a = 2'b00;
    push("clear_busy_cycles", 32'd32); pop_check(n);
    settle();
    push("clear_r4_dropped", 32'd0); pop_check(rd_a[31:0]);
    push("clear_r3_zero", 32'd0);    pop_check(rd_a[63:32]);
    ra_a = {5'd7, 5'd5}; settle();
    push("clear_r5_zero", 32'd0);    pop_check(rd_a[31:0]);
    push("clear_r7_zero", 32'd0);    pop_check(rd_a[63:32]);

    // Reset at sweep cycle 10, held for two edges, then a second request mid-sweep
    we_a = 2'b01; wa_a = {5'd0, 5'd20}; wd_a = {32'h0, 32'hCAFEF00D};
    @(negedge clk);
    we_a = 2'b00; ra_a = {5'd0, 5'd20}; settle();
    push("r20_loaded", 32'hCAFEF00D); pop_check(rd_a[31:0]);
    clear_req_a = 1'b1;
    @(negedge clk);
    clear_req_a = 1'b0;
    for (int k = 0; k < 10; k++) @(negedge clk);
    settle();
    push("midsweep_busy", 32'd1); pop_check({31'd0, busy_a});
    reset = 1'b1;
    @(negedge clk); settle();
    push("midreset_busy", 32'd1); pop_check({31'd0, busy_a});
    @(negedge clk);
    reset = 1'b0;
    settle();
    n = 0;
    for (int k = 0; k < 200; k++) begin
      if (!busy_a) break;
      n++;
      @(negedge clk);
      clear_req_a = (k == 4);
      settle();
    end
    clear_req_a = 1'b0;
    push("restart_busy_cycles", 32'd32); pop_check(n);
    push("restart_busy_b", 32'd0);       pop_check({31'd0, busy_b});
    push("restart_r20_zero", 32'd0);     pop_check(rd_a[31:0]);
    ra_b = 5'd0; settle();
    push("restart_b_r0_zero", 32'd0);    pop_check(rd_b);

    // Normal writes resume after the sweep
    we_a = 2'b01; wa_a = {5'd0, 5'd12}; wd_a = {32'h0, 32'h0BADF00D};
    @(negedge clk);
    we_a = 2'b00; ra_a = {5'd0, 5'd12}; settle();
    push("post_sweep_write", 32'h0BADF00D); pop_check(rd_a[31:0]);

    if (sb.size() != 0) begin
      n_cmp++;
      n_bad++;
      $error("FAIL sb_leftover observed=%0d required=0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
